// File: rtl/edge_pkg.sv
// Shared image geometry, BRAM label encoding and reader state encoding for the edge pipeline.
package edge_pkg;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int ADDR_W = 19;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int CNT_W  = 12;

  localparam logic [2:0] LBL_CLEAR    = 3'b000;
  localparam logic [2:0] LBL_CONTOUR  = 3'b001;
  localparam logic [2:0] LBL_RAW_EDGE = 3'b011;
  localparam logic [2:0] LBL_TRACED   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_CHECK,
    ST_EMIT,
    ST_ADV,
    ST_DONE
  } state_t;
endpackage

// File: rtl/bbox_tracker.sv
// Running contour statistics: saturating pixel count and min/max bounding box.
module bbox_tracker #(
  parameter int WIDTH  = edge_pkg::WIDTH,
  parameter int HEIGHT = edge_pkg::HEIGHT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        update,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic [11:0] num_pixels,
  output logic [9:0]  min_x,
  output logic [9:0]  max_x,
  output logic [8:0]  min_y,
  output logic [8:0]  max_y
);
  import edge_pkg::*;

  localparam logic [X_W-1:0]   X_INIT  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_INIT  = Y_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_pixels <= '0;
      min_x      <= X_INIT;
      max_x      <= '0;
      min_y      <= Y_INIT;
      max_y      <= '0;
    end else if (clear) begin
      num_pixels <= '0;
      min_x      <= X_INIT;
      max_x      <= '0;
      min_y      <= Y_INIT;
      max_y      <= '0;
    end else if (update) begin
      if (num_pixels != CNT_MAX) num_pixels <= num_pixels + 1'b1;
      if (x < min_x) min_x <= x;
      if (x > max_x) max_x <= x;
      if (y < min_y) min_y <= y;
      if (y > max_y) max_y <= y;
    end
  end
endmodule

// File: rtl/contour_reader.sv
// Raster-scans the finished edge BRAM, streams every contour-labelled (x,y) over valid/ready
// and accumulates the pixel count and bounding box for the wing-geometry stage.
module contour_reader #(
  parameter int         WIDTH        = edge_pkg::WIDTH,
  parameter int         HEIGHT       = edge_pkg::HEIGHT,
  parameter int         READ_LATENCY = 2,
  parameter logic [2:0] LABEL        = edge_pkg::LBL_CONTOUR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  bram_read,
  output logic [18:0] edge_addr_read,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] num_pixels,
  output logic [9:0]  min_x,
  output logic [9:0]  max_x,
  output logic [8:0]  min_y,
  output logic [8:0]  max_y,
  output logic        busy,
  output logic        done
);
  import edge_pkg::*;

  localparam int                LAT_W     = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

  state_t           state_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [X_W-1:0]   x_reg;
  logic [Y_W-1:0]   y_reg;
  logic             stats_clear;
  logic             stats_update;

  // Stats only move while enabled, so a start drop leaves them frozen.
  assign stats_clear  = start && (state_reg == ST_INIT);
  assign stats_update = start && (state_reg == ST_CHECK) && (bram_read == LABEL);

  bbox_tracker #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_bbox_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (stats_clear),
    .update     (stats_update),
    .x          (x_reg),
    .y          (y_reg),
    .num_pixels (num_pixels),
    .min_x      (min_x),
    .max_x      (max_x),
    .min_y      (min_y),
    .max_y      (max_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      lat_cnt_reg    <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      edge_addr_read <= '0;
      pix_valid      <= 1'b0;
      pix_x          <= '0;
      pix_y          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (!start) begin
      state_reg <= ST_IDLE;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!done) state_reg <= ST_INIT;
        end
        ST_INIT: begin
          edge_addr_read <= '0;
          x_reg          <= '0;
          y_reg          <= '0;
          lat_cnt_reg    <= LAT_LOAD;
          busy           <= 1'b1;
          state_reg      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt_reg == '0) state_reg <= ST_CHECK;
          else                   lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end
        ST_CHECK: begin
          if (bram_read == LABEL) begin
            pix_x     <= x_reg;
            pix_y     <= y_reg;
            pix_valid <= 1'b1;
            state_reg <= ST_EMIT;
          end else begin
            state_reg <= ST_ADV;
          end
        end
        ST_EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            state_reg <= ST_ADV;
          end
        end
        ST_ADV: begin
          if (edge_addr_read == LAST_ADDR) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            // Address and x/y counters step together; no y*WIDTH multiply needed.
            edge_addr_read <= edge_addr_read + 1'b1;
            if (x_reg == LAST_X) begin
              x_reg <= '0;
              y_reg <= y_reg + 1'b1;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
            lat_cnt_reg <= LAT_LOAD;
            state_reg   <= ST_WAIT;
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_contour_reader.sv
// Directed bench for contour_reader on a reduced 64x65 image with a 1-cycle BRAM model.
module tb_contour_reader;
  localparam int TB_W  = 64;
  localparam int TB_H  = 65;
  localparam int TB_RL = 1;
  localparam int NPIX  = TB_W * TB_H;
  localparam int SCAN  = NPIX * (TB_RL + 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [2:0]  bram_read;
  logic [18:0] edge_addr_read;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] num_pixels;
  logic [9:0]  min_x, max_x;
  logic [8:0]  min_y, max_y;
  logic        busy, done;

  logic [2:0] mem [NPIX];
  logic [2:0] rd_q = 3'b000;
  int         hs_x[$];
  int         hs_y[$];
  int         hs_done[$];
  int         valid_cnt = 0;
  bit         log_en = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         hs_base;
  int         vbase;
  int         cyc;
  int         stable;

  contour_reader #(
    .WIDTH        (TB_W),
    .HEIGHT       (TB_H),
    .READ_LATENCY (TB_RL),
    .LABEL        (3'b001)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .bram_read      (bram_read),
    .edge_addr_read (edge_addr_read),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .num_pixels     (num_pixels),
    .min_x          (min_x),
    .max_x          (max_x),
    .min_y          (min_y),
    .max_y          (max_y),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= mem[int'(edge_addr_read) % NPIX];
  assign bram_read = rd_q;

  always @(negedge clk) begin
    if (rst_n && pix_valid) begin
      valid_cnt <= valid_cnt + 1;
      if (pix_ready) begin
        hs_x.push_back(int'(pix_x));
        hs_y.push_back(int'(pix_y));
        hs_done.push_back(int'(done));
        if (log_en) $display("PIX x=%0d y=%0d", pix_x, pix_y);
      end
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int c;
    c = 0;
    while (pix_valid !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
  endtask

  task automatic wait_hs(input int n, input int budget);
    int c;
    c = 0;
    while ((hs_x.size() - hs_base) < n && c < budget) begin
      step(1);
      c++;
    end
  endtask

  task automatic fill_clear();
    for (int i = 0; i < NPIX; i++) mem[i] = 3'b000;
  endtask

  task automatic fill_three();
    fill_clear();
    mem[5 * TB_W + 10] = 3'b001;
    mem[5 * TB_W + 11] = 3'b001;
    mem[6 * TB_W + 10] = 3'b001;
  endtask

  task automatic stop_scan();
    start = 1'b0;
    step(1);
  endtask

  task automatic check_three(input string tag);
    check_eq({tag, "_hs_cnt"}, hs_x.size() - hs_base, 3);
    check_eq({tag, "_p0x"}, hs_x[hs_base], 10);
    check_eq({tag, "_p0y"}, hs_y[hs_base], 5);
    check_eq({tag, "_p1x"}, hs_x[hs_base + 1], 11);
    check_eq({tag, "_p2y"}, hs_y[hs_base + 2], 6);
    check_eq({tag, "_num"}, int'(num_pixels), 3);
    check_eq({tag, "_bbox"}, {22'd0, min_x, max_x} , {22'd0, 10'd10, 10'd11});
    check_eq({tag, "_ybox"}, {14'd0, min_y, max_y}, {14'd0, 9'd5, 9'd6});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_clear();
    step(3);
    check_eq("rst_addr", int'(edge_addr_read), 0);
    check_eq("rst_valid", int'(pix_valid), 0);
    check_eq("rst_num", int'(num_pixels), 0);
    check_eq("rst_min_x", int'(min_x), TB_W - 1);
    check_eq("rst_min_y", int'(min_y), TB_H - 1);
    check_eq("rst_busy_done", int'({busy, done}), 0);
    rst_n = 1'b1;
    step(2);

    // 1: empty image
    vbase = valid_cnt;
    hs_base = hs_x.size();
    start = 1'b1;
    step(1);
    step(1);
    check_eq("t1_busy", int'(busy), 1);
    wait_done(SCAN + 20, cyc);
    cyc += 2;
    check_eq("t1_done", int'(done), 1);
    check_eq("t1_cycles_in_range", int'(cyc >= SCAN && cyc <= SCAN + 4), 1);
    check_eq("t1_no_valid", valid_cnt - vbase, 0);
    check_eq("t1_num", int'(num_pixels), 0);
    check_eq("t1_min_x", int'(min_x), TB_W - 1);
    check_eq("t1_max_x", int'(max_x), 0);
    check_eq("t1_busy_at_done", int'(busy), 0);
    stop_scan();
    check_eq("t1_done_clear", int'(done), 0);

    // 2: three labelled pixels, consumer always ready
    fill_three();
    pix_ready = 1'b1;
    hs_base = hs_x.size();
    start = 1'b1;
    wait_done(SCAN + 40, cyc);
    check_eq("t2_done", int'(done), 1);
    check_three("t2");
    stop_scan();

    // 3: stall the first pixel for 20 cycles
    pix_ready = 1'b0;
    hs_base = hs_x.size();
    start = 1'b1;
    wait_valid(SCAN);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pix_valid === 1'b1 && pix_x == 10'd10 && pix_y == 9'd5) stable++;
    end
    check_eq("t3_stable", stable, 20);
    check_eq("t3_no_hs_while_stalled", hs_x.size() - hs_base, 0);
    pix_ready = 1'b1;
    wait_done(SCAN + 40, cyc);
    check_eq("t3_done", int'(done), 1);
    check_three("t3");
    stop_scan();

    // 4: mixed ignored labels, single contour pixel at the last address
    for (int i = 0; i < NPIX; i++) mem[i] = (i % 3 == 0) ? 3'b000 : ((i % 3 == 1) ? 3'b011 : 3'b111);
    mem[NPIX - 1] = 3'b001;
    pix_ready = 1'b0;
    hs_base = hs_x.size();
    start = 1'b1;
    wait_valid(SCAN + 20);
    check_eq("t4_valid", int'(pix_valid), 1);
    check_eq("t4_x", int'(pix_x), TB_W - 1);
    check_eq("t4_y", int'(pix_y), TB_H - 1);
    step(2);
    check_eq("t4_done_before_hs", int'(done), 0);
    pix_ready = 1'b1;
    wait_done(20, cyc);
    check_eq("t4_done", int'(done), 1);
    check_eq("t4_hs_cnt", hs_x.size() - hs_base, 1);
    check_eq("t4_done_at_hs", hs_done[hs_base], 0);
    check_eq("t4_num", int'(num_pixels), 1);
    check_eq("t4_bbox", {22'd0, min_x, max_x}, {22'd0, 10'd63, 10'd63});
    check_eq("t4_ybox", {14'd0, min_y, max_y}, {14'd0, 9'd64, 9'd64});
    stop_scan();

    // 5: drop start during EMIT, then rescan from the beginning
    fill_three();
    pix_ready = 1'b0;
    start = 1'b1;
    wait_valid(SCAN);
    check_eq("t5_first_x", int'(pix_x), 10);
    start = 1'b0;
    step(1);
    check_eq("t5_drop", int'({pix_valid, busy, done}), 0);
    check_eq("t5_stats_kept", int'(num_pixels), 1);
    hs_base = hs_x.size();
    pix_ready = 1'b1;
    start = 1'b1;
    step(2);
    check_eq("t5_rescan_addr", int'(edge_addr_read), 0);
    check_eq("t5_rescan_num", int'(num_pixels), 0);
    check_eq("t5_rescan_min_x", int'(min_x), TB_W - 1);
    check_eq("t5_rescan_busy", int'(busy), 1);
    wait_hs(1, SCAN);
    check_eq("t5_rescan_px", hs_x[hs_base], 10);
    check_eq("t5_rescan_py", hs_y[hs_base], 5);
    stop_scan();

    // 6: async reset mid-WAIT, then saturate the counter
    for (int i = 0; i < NPIX; i++) mem[i] = (i < 4100) ? 3'b001 : 3'b000;
    log_en = 1'b0;
    pix_ready = 1'b1;
    hs_base = hs_x.size();
    start = 1'b1;
    wait_hs(5, 200);
    wait_valid(20);
    step(2);
    #1;
    check_eq("t6_pre_busy", int'(busy), 1);
    check_eq("t6_pre_num_nz", int'(num_pixels != 12'd0), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_addr", int'(edge_addr_read), 0);
    check_eq("t6_async_num", int'(num_pixels), 0);
    check_eq("t6_async_busy", int'(busy), 0);
    check_eq("t6_async_valid", int'(pix_valid), 0);
    check_eq("t6_async_min_x", int'(min_x), TB_W - 1);
    check_eq("t6_async_max_x", int'(max_x), 0);
    step(1);
    rst_n = 1'b1;
    hs_base = hs_x.size();
    wait_hs(4100, 4100 * (TB_RL + 3) + 100);
    step(3);
    check_eq("t6_hs_cnt", hs_x.size() - hs_base, 4100);
    check_eq("t6_num_sat", int'(num_pixels), 4095);
    check_eq("t6_max_y", int'(max_y), 64);
    check_eq("t6_bbox_x", {22'd0, min_x, max_x}, {22'd0, 10'd0, 10'd63});
    $display("SAT handshakes=%0d num_pixels=%0d", hs_x.size() - hs_base, num_pixels);
    stop_scan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
